// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and flag types for alu_secuencial.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b000011;
  localparam logic [5:0] OP_OR  = 6'b000100;
  localparam logic [5:0] OP_XOR = 6'b000101;
  localparam logic [5:0] OP_SHL = 6'b000110;
  localparam logic [5:0] OP_SHR = 6'b000111;
  localparam logic [5:0] OP_SRA = 6'b001000;
  localparam logic [5:0] OP_MUL = 6'b001001;
  localparam logic [5:0] OP_DIV = 6'b001010;

  typedef enum logic {IDLE, CALC} alu_estado_t;

  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
  } alu_flags_t;

  function automatic logic es_muldiv(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/adder_substractor.sv
// Combinational n-bit adder/subtractor: resta=1 computes a + ~b + 1.
module adder_substractor #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         resta,
  output logic [n-1:0] resultado,
  output logic         carry,
  output logic         overflow
);

  logic [n-1:0] b_efectivo;

  // Invert B for subtraction; carry-out then means "no borrow".
  always_comb begin
    b_efectivo = resta ? ~b : b;
    {carry, resultado} = {1'b0, a} + {1'b0, b_efectivo} + {{n{1'b0}}, resta};
    overflow = (a[n-1] == b_efectivo[n-1]) && (resultado[n-1] != a[n-1]);
  end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned MUL (shift-add) and DIV (restoring), one bit per step.
// Present only when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cargar,
  input  logic         paso,
  input  logic         es_div_in,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         ultimo,
  output logic         es_div,
  output logic         b_cero,
  output logic [n-1:0] lo_sig,
  output logic [n-1:0] hi_sig
);

  localparam int CW = $clog2(n) + 1;

  logic [n-1:0]  acc;
  logic [n-1:0]  q;
  logic [n-1:0]  op_b;
  logic [CW-1:0] cnt;
  logic [n:0]    suma;
  logic [n:0]    desp;
  logic [n:0]    dif;

  assign ultimo = (cnt == CW'(1));
  assign b_cero = (op_b == '0);

  // Next accumulator/shift-register values for the current step; the top
  // registers these directly on the final step.
  always_comb begin
    suma = {1'b0, acc} + (q[0] ? {1'b0, op_b} : '0);
    desp = {acc, q[n-1]};
    dif  = desp - {1'b0, op_b};
    if (es_div) begin
      hi_sig = dif[n] ? desp[n-1:0] : dif[n-1:0];
      lo_sig = {q[n-2:0], ~dif[n]};
    end else begin
      hi_sig = suma[n:1];
      lo_sig = {suma[0], q[n-1:1]};
    end
  end

  // Operand capture at acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      q      <= '0;
      op_b   <= '0;
      cnt    <= '0;
      es_div <= 1'b0;
    end else if (cargar) begin
      acc    <= '0;
      q      <= a;
      op_b   <= b;
      cnt    <= CW'(n);
      es_div <= es_div_in;
    end else if (paso) begin
      acc <= hi_sig;
      q   <= lo_sig;
      cnt <= cnt - CW'(1);
    end
  end

endmodule
`endif

// File: rtl/alu_secuencial.sv
// Registered ALU with start/done handshake and NZCV flags.
// Define ALU_MULDIV_EN to compile in the iterative MUL/DIV path.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   control,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] salida,
  output logic [n-1:0] salida_alta,
  output logic         N,
  output logic         Z,
  output logic         C,
  output logic         V,
  output logic         invalido
);

  localparam int SH = $clog2(n);

  alu_estado_t  estado, estado_sig;
  alu_flags_t   flags, flags_d, fl_uno;
  logic [n-1:0] salida_d, alta_d, res_uno;
  logic [n-1:0] suma_res;
  logic         suma_c, suma_v;
  logic         done_d, inv_d, inv_uno;
  logic         arranca_md;
  logic [SH-1:0] sh;

  assign sh = B[SH-1:0];
  assign {N, Z, C, V} = flags;

  adder_substractor #(.n(n)) u_addsub (
    .a         (A),
    .b         (B),
    .resta     (control == OP_SUB),
    .resultado (suma_res),
    .carry     (suma_c),
    .overflow  (suma_v)
  );

`ifdef ALU_MULDIV_EN
  logic [n-1:0] md_lo, md_hi;
  logic         md_ultimo, md_es_div, md_b_cero, md_cargar;

  assign arranca_md = es_muldiv(control);
  assign md_cargar  = (estado == IDLE) && start && arranca_md;
  assign busy       = (estado == CALC);

  alu_muldiv_iter #(.n(n)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .cargar    (md_cargar),
    .paso      (estado == CALC),
    .es_div_in (control == OP_DIV),
    .a         (A),
    .b         (B),
    .ultimo    (md_ultimo),
    .es_div    (md_es_div),
    .b_cero    (md_b_cero),
    .lo_sig    (md_lo),
    .hi_sig    (md_hi)
  );
`else
  assign arranca_md = 1'b0;
  assign busy       = 1'b0;
`endif

  // Single-cycle result and flags; MUL/DIV codes decode as invalid here.
  always_comb begin
    res_uno = '0;
    fl_uno  = '0;
    inv_uno = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        res_uno  = suma_res;
        fl_uno.C = suma_c;
        fl_uno.V = suma_v;
      end
      OP_AND: res_uno = A & B;
      OP_OR:  res_uno = A | B;
      OP_XOR: res_uno = A ^ B;
      // An extra bit beside the operand catches the last bit shifted out.
      OP_SHL: {fl_uno.C, res_uno} = {1'b0, A} << sh;
      OP_SHR: {res_uno, fl_uno.C} = {A, 1'b0} >> sh;
      OP_SRA: {res_uno, fl_uno.C} = $signed({A, 1'b0}) >>> sh;
      default: inv_uno = 1'b1;
    endcase
    if (!inv_uno) begin
      fl_uno.N = res_uno[n-1];
      fl_uno.Z = (res_uno == '0);
    end
  end

  // Next state and next registered outputs; outputs hold unless completing.
  always_comb begin
    estado_sig = estado;
    salida_d   = salida;
    alta_d     = salida_alta;
    flags_d    = flags;
    inv_d      = invalido;
    done_d     = 1'b0;
    case (estado)
      IDLE: begin
        if (start) begin
          if (arranca_md) begin
            estado_sig = CALC;
          end else begin
            salida_d = res_uno;
            alta_d   = '0;
            flags_d  = fl_uno;
            inv_d    = inv_uno;
            done_d   = 1'b1;
          end
        end
      end
      CALC: begin
`ifdef ALU_MULDIV_EN
        if (md_ultimo) begin
          estado_sig = IDLE;
          salida_d   = md_lo;
          alta_d     = md_hi;
          flags_d.N  = md_lo[n-1];
          flags_d.Z  = (md_lo == '0);
          flags_d.C  = !md_es_div && (md_hi != '0);
          flags_d.V  = md_es_div && md_b_cero;
          inv_d      = 1'b0;
          done_d     = 1'b1;
        end
`else
        estado_sig = IDLE;
`endif
      end
      default: estado_sig = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= IDLE;
      salida      <= '0;
      salida_alta <= '0;
      flags       <= '0;
      invalido    <= 1'b0;
      done        <= 1'b0;
    end else begin
      estado      <= estado_sig;
      salida      <= salida_d;
      salida_alta <= alta_d;
      flags       <= flags_d;
      invalido    <= inv_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed self-checking bench for alu_secuencial (n=32).
module tb_alu_secuencial;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [5:0]   control;
  logic [W-1:0] A, B;
  logic         busy, done, N, Z, C, V, invalido;
  logic [W-1:0] salida, salida_alta;

  int n_pruebas = 0;
  int n_fallos  = 0;

  always #5 clk = ~clk;

  alu_secuencial #(.n(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .control     (control),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .salida      (salida),
    .salida_alta (salida_alta),
    .N           (N),
    .Z           (Z),
    .C           (C),
    .V           (V),
    .invalido    (invalido)
  );

  task automatic verificar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_pruebas++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: obtenido=0x%0h esperado=0x%0h", tag, obs, esp);
    end
  endtask

  // Present one request for a single cycle; afterwards scramble the inputs so
  // that any late sampling shows up in the results.
  task automatic lanzar(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start   = 1'b1;
    control = op;
    A       = a;
    B       = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    control = 6'b000000;
    A       = ~a;
    B       = ~b;
  endtask

  task automatic simple(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] esp, input logic [3:0] fl);
    lanzar(op, a, b);
    verificar({tag, ".done"}, done, 1);
    verificar({tag, ".salida"}, salida, esp);
    verificar({tag, ".nzcv"}, {N, Z, C, V}, fl);
    verificar({tag, ".alta"}, salida_alta, 0);
    verificar({tag, ".inv"}, invalido, 0);
  endtask

  task automatic multi(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] esp_lo,
                       input logic [W-1:0] esp_hi, input logic [3:0] fl);
    int  lat;
    bit  busy_ok;
    busy_ok = 1'b1;
    lanzar(op, a, b);
    lat = 1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == 3) begin
        start = 1'b1; control = OP_ADD; A = 1; B = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    verificar({tag, ".latencia"}, lat, W + 1);
    verificar({tag, ".busy_calc"}, busy_ok, 1);
    verificar({tag, ".busy_fin"}, busy, 0);
    verificar({tag, ".salida"}, salida, esp_lo);
    verificar({tag, ".alta"}, salida_alta, esp_hi);
    verificar({tag, ".nzcv"}, {N, Z, C, V}, fl);
    verificar({tag, ".inv"}, invalido, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; control = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    verificar("reset.salida", salida, 0);
    verificar("reset.alta", salida_alta, 0);
    verificar("reset.nzcv", {N, Z, C, V}, 0);
    verificar("reset.ctrl", {busy, done, invalido}, 0);
    @(negedge clk);
    rst = 1'b0;

    simple("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    @(posedge clk); #1;
    verificar("pulso.done", done, 0);
    verificar("pulso.hold", salida, 32'h8000_0000);
    verificar("pulso.hold_nzcv", {N, Z, C, V}, 4'b1001);

    simple("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
    simple("sub_igual", OP_SUB, 32'd5, 32'd5, 32'h0, 4'b0110);
    simple("sub_borrow", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000);
    simple("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000);
    simple("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b1000);
    simple("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
    simple("shl", OP_SHL, 32'h8000_0001, 32'd1, 32'h0000_0002, 4'b0010);
    simple("shl_cero", OP_SHL, 32'h8000_0001, 32'd32, 32'h8000_0001, 4'b1000);
    simple("shr", OP_SHR, 32'h0000_0003, 32'd1, 32'h0000_0001, 4'b0010);
    simple("sra", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 4'b1000);

    lanzar(6'b111111, 32'h1234, 32'h5678);
    verificar("inv.done", done, 1);
    verificar("inv.flag", invalido, 1);
    verificar("inv.salida", salida, 0);
    verificar("inv.alta", salida_alta, 0);
    verificar("inv.nzcv", {N, Z, C, V}, 0);
    simple("tras_inv", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);

`ifdef ALU_MULDIV_EN
    multi("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h1, 4'b1010);
    @(posedge clk); #1;
    verificar("mul.pulso", {done, busy}, 0);
    multi("mul_alto", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 4'b0110);
    multi("div", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
    multi("div_cero", OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 4'b1001);
    simple("b2b", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);

    begin
      int dones;
      dones = 0;
      lanzar(OP_MUL, 32'd3, 32'd5);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      verificar("rst_mul.ctrl", {busy, done, invalido}, 0);
      verificar("rst_mul.salida", salida, 0);
      verificar("rst_mul.alta", salida_alta, 0);
      verificar("rst_mul.nzcv", {N, Z, C, V}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done || busy) dones++;
      end
      verificar("rst_mul.sin_done", dones, 0);
    end
`else
    lanzar(OP_MUL, 32'd3, 32'd4);
    verificar("mul_off.done", done, 1);
    verificar("mul_off.inv", invalido, 1);
    verificar("mul_off.salida", salida, 0);
    verificar("mul_off.alta", salida_alta, 0);
    verificar("mul_off.busy", busy, 0);
    simple("tras_mul_off", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);
    lanzar(OP_DIV, 32'd100, 32'd7);
    verificar("div_off.done", done, 1);
    verificar("div_off.inv", invalido, 1);
    verificar("div_off.salida", salida, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_pruebas, n_fallos);
    $finish;
  end

endmodule

// File: doc/alu_secuencial.md
# alu_secuencial

Registered, parametrised ALU for the datapath execute stage, with a start/done handshake. Single-cycle operations (add, sub, logic, shifts) produce a registered result one cycle after acceptance. Optional multi-cycle unsigned multiply and divide run iteratively, one bit per cycle. NZCV flags are registered together with the result and hold until the next completion.

## Interface
- `n`, default 32: operand and result width, ≥ 4, power of two.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `control` input 6: operation code.
- `A`, `B` input n: operands, sampled with `start`.
- `busy` output 1: a multi-cycle operation is in progress.
- `done` output 1: one-cycle pulse; `salida`, `salida_alta` and flags are updated in that same cycle.
- `salida` output n: result (low half for MUL, quotient for DIV).
- `salida_alta` output n: MUL high half or DIV remainder; 0 for all other ops.
- `N`, `Z`, `C`, `V` output 1 each: Negative, Zero, Carry, Overflow.
- `invalido` output 1: set with `done` when `control` is an unsupported code.

## Operation
- Codes:
  - 000001 ADD, 000010 SUB, 000011 AND, 000100 OR, 000101 XOR.
  - 000110 SHL, 000111 SHR, 001000 SRA.
  - 001001 MUL, 001010 DIV (both unsigned).
  - Any other code is invalid.
- Shift amount is `B[$clog2(n)-1:0]`; upper bits of `B` are ignored.
- ADD: C = carry-out; V = signed overflow.
- SUB: computes A + ~B + 1. C = 1 when A ≥ B unsigned (no borrow); V = signed overflow.
- Logic ops: C=0, V=0.
- Shifts: C = last bit shifted out, 0 when the amount is 0; V=0.
- MUL: `{salida_alta,salida}` = A·B (2n bits). C = (`salida_alta`≠0); V=0.
- DIV: `salida` = A/B, `salida_alta` = A mod B.
  - B=0 gives `salida` all ones, `salida_alta` = A, V=1, C=0.
- N = `salida[n-1]` and Z = (`salida`==0) for every valid op; low half only for MUL.
- Invalid code: `salida`=0, `salida_alta`=0, flags all 0, `invalido`=1, latency 1.
- States: IDLE, CALC.
  - IDLE, `start`, single-cycle or invalid op: register the result and pulse `done` on the next cycle; stay in IDLE.
  - IDLE, `start`, MUL/DIV: latch operands, load counter with n, go to CALC.
  - CALC: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle; counter decrements.
  - After the step that brings the counter to 0: register the result, pulse `done`, go to IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- Operands are captured at acceptance; later changes to `A`, `B` or `control` have no effect.
- Outputs hold their last completed values between `done` pulses.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `invalido`=0, `salida`=0, `salida_alta`=0, N=Z=C=V=0.
- `rst` mid-CALC aborts the operation: no `done`, and outputs return to their reset values.
- Single-cycle op accepted at edge t: `done`=1 during the cycle after edge t+1, for exactly one cycle.
- MUL/DIV accepted at edge t:
  - `busy`=1 from edge t+1 through edge t+n.
  - `done`=1 after edge t+n+1, i.e. latency n+1 cycles; `busy`=0 in that cycle.
- A new `start` is accepted in the same cycle `done` is high (back-to-back, no bubble).

## Configuration
- `ALU_MULDIV_EN` defined: MUL/DIV datapath, counter and CALC state are compiled in, as above.
- `ALU_MULDIV_EN` undefined:
  - Codes 001001 and 001010 are treated as invalid (latency 1, `invalido`=1).
  - `busy` is tied to 0 and `salida_alta` to 0.
  - No CALC state exists.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (`OP_ADD` … `OP_DIV`);
  - state enum `alu_estado_t` {IDLE, CALC};
  - flag struct `alu_flags_t` {N,Z,C,V}.
- Single-cycle ops use the existing `adder_substractor` for ADD/SUB.
- One sub-module, `alu_muldiv_iter`: it holds the iterative MUL/DIV datapath (accumulator, operand shift register, counter) and is instantiated only under `ALU_MULDIV_EN`.

## Test plan
- n=32, ADD A=0x7FFFFFFF, B=1 → `salida`=0x80000000, N=1, Z=0, C=0, V=1, `done` one cycle after acceptance.
- SUB A=5, B=5 → 0, Z=1, C=1, V=0; then SUB A=0, B=1 → 0xFFFFFFFF, N=1, C=0.
- SHL A=0x80000001, B=1 → 0x00000002, C=1; SRA A=0x80000000, B=31 → 0xFFFFFFFF, N=1.
- MUL A=0xFFFFFFFF, B=2 → `salida`=0xFFFFFFFE, `salida_alta`=1, C=1, `done` exactly 33 cycles after acceptance; a second `start` during `busy` is ignored.
- DIV A=100, B=7 → 14 rem 2; DIV A=9, B=0 → `salida`=0xFFFFFFFF, `salida_alta`=9, V=1.
- `control`=111111 → `invalido`=1, `salida`=0. Assert `rst` mid-MUL → no `done`, all outputs 0 on the next cycle.
- Without `ALU_MULDIV_EN`, MUL → `invalido`=1 with latency 1.
